// File: rtl/arith_tb_pkg.sv
// Shared definitions for the arithmetic monitor.
//   OP_ADD / OP_SUB / OP_MUL : encodings of the reference function.
//   op_e                      : typed view of the same encodings.
//   sat_inc()                 : increment that holds at a caller-supplied maximum.
package arith_tb_pkg;

    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_MUL = 2;

    typedef enum logic [1:0] {
        OpAdd = 2'd0,
        OpSub = 2'd1,
        OpMul = 2'd2
    } op_e;

    // Operands are carried at 64 bits so that one function serves any counter width up to 64;
    // callers zero-extend on the way in and truncate on the way out.
    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input logic [63:0] max_value);
        return (value >= max_value) ? value : value + 64'd1;
    endfunction

endpackage

// File: rtl/arith_ref_lane.sv
// Pipelined reference model for one monitor lane.
// Computes the reference function on a/b and presents the result REF_LAT cycles later.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   a, b          operands (held stable by the owning lane while a check is in flight)
//   expected      reference result, REF_LAT cycles after a/b
module arith_ref_lane
    import arith_tb_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned OP      = OP_ADD,
    parameter int unsigned REF_LAT = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] expected
);

    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] stage_q [REF_LAT];

    // All arithmetic is modulo 2^WIDTH: operands and result share one width.
    generate
        if (OP == OP_SUB) begin : g_sub
            assign result = a - b;
        end else if (OP == OP_MUL) begin : g_mul
            assign result = a * b;
        end else begin : g_add
            assign result = a + b;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(REF_LAT); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= result;
            for (int i = 1; i < int'(REF_LAT); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign expected = stage_q[REF_LAT-1];

endmodule

// File: rtl/arith_monitor_mc.sv
// Multi-lane self-checking monitor for an arithmetic DUT.
// Valid operand/result triples are dealt round-robin to NUM_LANES lanes; each lane waits for
// its reference result (REF_LAT cycles) and compares it against the DUT result.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   i_clear                      synchronous clear of counters, sticky flag and capture
//   i_valid, i_dut_ia/ib/os      DUT operand/result triple
//   o_ready                      monitor accepting samples (rises one edge after reset)
//   o_event                      one-cycle pulse per mismatch
//   o_chk_cnt/err_cnt/drop_cnt   saturating check / mismatch / drop counters
//   o_overflow                   sticky: a sample was dropped
//   o_first_vld, o_first_*       first failing vector and its expected value
// Build option: define ARITH_MON_FIRST_CAPTURE_EN to build the first-mismatch capture;
// otherwise o_first_vld and o_first_* are tied to 0.
module arith_monitor_mc
    import arith_tb_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned REF_LAT   = 3,
    parameter int unsigned OP        = OP_ADD,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_dut_ia,
    input  logic [WIDTH-1:0] i_dut_ib,
    input  logic [WIDTH-1:0] i_dut_os,
    output logic             o_ready,
    output logic             o_event,
    output logic [CNT_W-1:0] o_chk_cnt,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_drop_cnt,
    output logic             o_overflow,
    output logic             o_first_vld,
    output logic [WIDTH-1:0] o_first_a,
    output logic [WIDTH-1:0] o_first_b,
    output logic [WIDTH-1:0] o_first_os,
    output logic [WIDTH-1:0] o_first_exp
);

    localparam int unsigned PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned LCW   = $clog2(REF_LAT + 1);
    localparam logic [63:0] CNT_MAX = (CNT_W >= 64) ? {64{1'b1}} :
                                                      ((64'd1 << CNT_W) - 64'd1);

    // ------------------------------------------------------------------
    // Lane state
    // ------------------------------------------------------------------
    logic [NUM_LANES-1:0] lane_busy_q, lane_busy_d;
    logic [LCW-1:0]       lane_cnt_q [NUM_LANES];
    logic [LCW-1:0]       lane_cnt_d [NUM_LANES];
    logic [WIDTH-1:0]     lane_a_q   [NUM_LANES];
    logic [WIDTH-1:0]     lane_a_d   [NUM_LANES];
    logic [WIDTH-1:0]     lane_b_q   [NUM_LANES];
    logic [WIDTH-1:0]     lane_b_d   [NUM_LANES];
    logic [WIDTH-1:0]     lane_os_q  [NUM_LANES];
    logic [WIDTH-1:0]     lane_os_d  [NUM_LANES];
    logic [WIDTH-1:0]     lane_exp   [NUM_LANES];

    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 ready_q;

    logic [NUM_LANES-1:0] done;
    logic [NUM_LANES-1:0] sel;
    logic                 any_done;
    logic                 any_mis;
    logic                 ptr_blocked;
    logic                 accept;
    logic                 drop;

    logic [CNT_W-1:0]     chk_cnt_q, chk_cnt_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
    logic                 overflow_q, overflow_d;
    logic                 event_q, event_d;

    generate
        for (genvar g = 0; g < int'(NUM_LANES); g++) begin : g_lane
            arith_ref_lane #(
                .WIDTH   (WIDTH),
                .OP      (OP),
                .REF_LAT (REF_LAT)
            ) u_ref (
                .clk      (clk),
                .reset_n  (reset_n),
                .a        (lane_a_q[g]),
                .b        (lane_b_q[g]),
                .expected (lane_exp[g])
            );
        end
    endgenerate

    // Completion detect and lane selection. A lane completes when its counter has run down to
    // zero; at most one lane can complete per cycle since accepts are one per cycle.
    always_comb begin
        done     = '0;
        sel      = '0;
        any_done = 1'b0;
        any_mis  = 1'b0;
        for (int l = 0; l < int'(NUM_LANES); l++) begin
            done[l] = lane_busy_q[l] && (lane_cnt_q[l] == '0);
            sel[l]  = (ptr_q == PTR_W'(l));
            if (done[l]) begin
                any_done = 1'b1;
                if (lane_os_q[l] != lane_exp[l]) begin
                    any_mis = 1'b1;
                end
            end
        end
        // A lane finishing on this edge counts as free.
        ptr_blocked = |(sel & lane_busy_q & ~done);
        accept      = i_valid && ready_q && !ptr_blocked;
        drop        = i_valid && ready_q && ptr_blocked;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (ptr_q == PTR_W'(NUM_LANES - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    // Lane next-state: a new capture takes priority over the completion of the old sample.
    always_comb begin
        lane_busy_d = lane_busy_q;
        for (int l = 0; l < int'(NUM_LANES); l++) begin
            lane_cnt_d[l] = lane_cnt_q[l];
            lane_a_d[l]   = lane_a_q[l];
            lane_b_d[l]   = lane_b_q[l];
            lane_os_d[l]  = lane_os_q[l];
            if (accept && sel[l]) begin
                lane_busy_d[l] = 1'b1;
                lane_cnt_d[l]  = LCW'(REF_LAT);
                lane_a_d[l]    = i_dut_ia;
                lane_b_d[l]    = i_dut_ib;
                lane_os_d[l]   = i_dut_os;
            end else if (done[l]) begin
                lane_busy_d[l] = 1'b0;
            end else if (lane_busy_q[l]) begin
                lane_cnt_d[l] = lane_cnt_q[l] - LCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_busy_q <= '0;
            ptr_q       <= '0;
            ready_q     <= 1'b0;
            for (int l = 0; l < int'(NUM_LANES); l++) begin
                lane_cnt_q[l] <= '0;
                lane_a_q[l]   <= '0;
                lane_b_q[l]   <= '0;
                lane_os_q[l]  <= '0;
            end
        end else begin
            lane_busy_q <= lane_busy_d;
            ptr_q       <= ptr_d;
            ready_q     <= 1'b1;
            for (int l = 0; l < int'(NUM_LANES); l++) begin
                lane_cnt_q[l] <= lane_cnt_d[l];
                lane_a_q[l]   <= lane_a_d[l];
                lane_b_q[l]   <= lane_b_d[l];
                lane_os_q[l]  <= lane_os_d[l];
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters and event. Clear wins over anything completing or dropping on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        chk_cnt_d  = chk_cnt_q;
        err_cnt_d  = err_cnt_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        event_d    = 1'b0;
        if (i_clear) begin
            chk_cnt_d  = '0;
            err_cnt_d  = '0;
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end else begin
            if (any_done) begin
                chk_cnt_d = CNT_W'(sat_inc(64'(chk_cnt_q), CNT_MAX));
            end
            if (any_mis) begin
                err_cnt_d = CNT_W'(sat_inc(64'(err_cnt_q), CNT_MAX));
                event_d   = 1'b1;
            end
            if (drop) begin
                drop_cnt_d = CNT_W'(sat_inc(64'(drop_cnt_q), CNT_MAX));
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chk_cnt_q  <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
            event_q    <= 1'b0;
        end else begin
            chk_cnt_q  <= chk_cnt_d;
            err_cnt_q  <= err_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
            event_q    <= event_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_event    = event_q;
    assign o_chk_cnt  = chk_cnt_q;
    assign o_err_cnt  = err_cnt_q;
    assign o_drop_cnt = drop_cnt_q;
    assign o_overflow = overflow_q;

    // ------------------------------------------------------------------
    // First-mismatch capture
    // ------------------------------------------------------------------
`ifdef ARITH_MON_FIRST_CAPTURE_EN
    logic [WIDTH-1:0] done_a, done_b, done_os, done_exp;
    logic             first_vld_q, first_vld_d;
    logic [WIDTH-1:0] first_a_q, first_a_d;
    logic [WIDTH-1:0] first_b_q, first_b_d;
    logic [WIDTH-1:0] first_os_q, first_os_d;
    logic [WIDTH-1:0] first_exp_q, first_exp_d;

    // Only one lane can be done at a time, so this simply picks it out.
    always_comb begin
        done_a   = '0;
        done_b   = '0;
        done_os  = '0;
        done_exp = '0;
        for (int l = 0; l < int'(NUM_LANES); l++) begin
            if (done[l]) begin
                done_a   = lane_a_q[l];
                done_b   = lane_b_q[l];
                done_os  = lane_os_q[l];
                done_exp = lane_exp[l];
            end
        end
    end

    always_comb begin
        first_vld_d = first_vld_q;
        first_a_d   = first_a_q;
        first_b_d   = first_b_q;
        first_os_d  = first_os_q;
        first_exp_d = first_exp_q;
        if (i_clear) begin
            first_vld_d = 1'b0;
            first_a_d   = '0;
            first_b_d   = '0;
            first_os_d  = '0;
            first_exp_d = '0;
        end else if (any_mis && !first_vld_q) begin
            first_vld_d = 1'b1;
            first_a_d   = done_a;
            first_b_d   = done_b;
            first_os_d  = done_os;
            first_exp_d = done_exp;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_vld_q <= 1'b0;
            first_a_q   <= '0;
            first_b_q   <= '0;
            first_os_q  <= '0;
            first_exp_q <= '0;
        end else begin
            first_vld_q <= first_vld_d;
            first_a_q   <= first_a_d;
            first_b_q   <= first_b_d;
            first_os_q  <= first_os_d;
            first_exp_q <= first_exp_d;
        end
    end

    assign o_first_vld = first_vld_q;
    assign o_first_a   = first_a_q;
    assign o_first_b   = first_b_q;
    assign o_first_os  = first_os_q;
    assign o_first_exp = first_exp_q;
`else
    assign o_first_vld = 1'b0;
    assign o_first_a   = '0;
    assign o_first_b   = '0;
    assign o_first_os  = '0;
    assign o_first_exp = '0;
`endif

endmodule

// File: tb/tb_arith_monitor_mc.sv
// Scoreboard bench for arith_monitor_mc (WIDTH=16, NUM_LANES=2, REF_LAT=3, OP=add, CNT_W=4).
// The stimulus side decides from lane free-times which samples are accepted or dropped and
// queues the expected outcomes; a separate monitor compares every output after every edge.
module tb_arith_monitor_mc;

    localparam int unsigned W   = 16;
    localparam int unsigned NL  = 2;
    localparam int unsigned RL  = 3;
    localparam int unsigned OPS = 0;
    localparam int unsigned CW  = 4;
    localparam int          CMAX = (1 << CW) - 1;
`ifdef ARITH_MON_FIRST_CAPTURE_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          i_clear;
    logic          i_valid;
    logic [W-1:0]  i_dut_ia, i_dut_ib, i_dut_os;
    logic          o_ready, o_event, o_overflow, o_first_vld;
    logic [CW-1:0] o_chk_cnt, o_err_cnt, o_drop_cnt;
    logic [W-1:0]  o_first_a, o_first_b, o_first_os, o_first_exp;

    arith_monitor_mc #(
        .WIDTH     (W),
        .NUM_LANES (NL),
        .REF_LAT   (RL),
        .OP        (OPS),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clear     (i_clear),
        .i_valid     (i_valid),
        .i_dut_ia    (i_dut_ia),
        .i_dut_ib    (i_dut_ib),
        .i_dut_os    (i_dut_os),
        .o_ready     (o_ready),
        .o_event     (o_event),
        .o_chk_cnt   (o_chk_cnt),
        .o_err_cnt   (o_err_cnt),
        .o_drop_cnt  (o_drop_cnt),
        .o_overflow  (o_overflow),
        .o_first_vld (o_first_vld),
        .o_first_a   (o_first_a),
        .o_first_b   (o_first_b),
        .o_first_os  (o_first_os),
        .o_first_exp (o_first_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int           due;
        bit           mis;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] os;
        logic [W-1:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  drop_q[$];
    int  clr_q[$];

    int checks = 0;
    int errors = 0;

    // Stimulus-side model: which lane is next and when each lane becomes free again.
    int ptr = 0;
    int free_at[NL];

    function automatic logic [W-1:0] ref_fn(input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned x, y, r;
        x = longint'(a);
        y = longint'(b);
        case (OPS)
            1:       r = x - y;
            2:       r = x * y;
            default: r = x + y;
        endcase
        return W'(r % (64'd1 << W));
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, applied after the falling edge for the next rising edge.
    task automatic drive(input bit valid, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] os, input bit clr);
        int  e;
        sb_t s;
        @(negedge clk);
        e        = edge_n + 1;
        i_valid  = valid;
        i_dut_ia = a;
        i_dut_ib = b;
        i_dut_os = os;
        i_clear  = clr;
        if (clr) clr_q.push_back(e);
        if (valid) begin
            if (e >= free_at[ptr]) begin
                s.due = e + int'(RL) + 1;
                s.a   = a;
                s.b   = b;
                s.os  = os;
                s.exp = ref_fn(a, b);
                s.mis = (os != s.exp);
                sb_q.push_back(s);
                free_at[ptr] = s.due;
                ptr = (ptr + 1) % int'(NL);
            end else begin
                drop_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, o_ready, 0);
        check({tag, "_event"}, o_event, 0);
        check({tag, "_chk"}, o_chk_cnt, 0);
        check({tag, "_err"}, o_err_cnt, 0);
        check({tag, "_drop"}, o_drop_cnt, 0);
        check({tag, "_ovf"}, o_overflow, 0);
        check({tag, "_fvld"}, o_first_vld, 0);
        check({tag, "_fa"}, o_first_a, 0);
        check({tag, "_fb"}, o_first_b, 0);
        check({tag, "_fos"}, o_first_os, 0);
        check({tag, "_fexp"}, o_first_exp, 0);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic apply_reset(input string tag);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        i_valid = 1'b0;
        i_clear = 1'b0;
        #1;
        check_all_zero(tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        ptr = 0;
        for (int l = 0; l < int'(NL); l++) free_at[l] = 0;
    endtask

    // ------------------------------------------------------------------
    // Monitor: expected counter state, updated from the queued outcomes for each edge.
    // ------------------------------------------------------------------
    int           m_chk, m_err, m_drop;
    bit           m_ovf, m_fv;
    logic [W-1:0] m_fa, m_fb, m_fos, m_fexp;

    initial begin
        sb_t c;
        bit  have_c, clr, drp, ev;
        int  e;
        m_chk = 0; m_err = 0; m_drop = 0; m_ovf = 0; m_fv = 0;
        m_fa = '0; m_fb = '0; m_fos = '0; m_fexp = '0;
        forever begin
            @(posedge clk);
            #1;
            e = edge_n;
            if (!reset_n) begin
                sb_q.delete();
                drop_q.delete();
                clr_q.delete();
                m_chk = 0; m_err = 0; m_drop = 0; m_ovf = 0; m_fv = 0;
                m_fa = '0; m_fb = '0; m_fos = '0; m_fexp = '0;
            end else begin
                clr    = (clr_q.size() > 0) && (clr_q[0] == e);
                have_c = (sb_q.size() > 0) && (sb_q[0].due == e);
                drp    = (drop_q.size() > 0) && (drop_q[0] == e);
                if (clr) void'(clr_q.pop_front());
                if (have_c) c = sb_q.pop_front();
                if (drp) void'(drop_q.pop_front());
                ev = 1'b0;
                if (clr) begin
                    m_chk = 0; m_err = 0; m_drop = 0; m_ovf = 0; m_fv = 0;
                    m_fa = '0; m_fb = '0; m_fos = '0; m_fexp = '0;
                end else begin
                    if (have_c) begin
                        if (m_chk < CMAX) m_chk++;
                        if (c.mis) begin
                            ev = 1'b1;
                            if (m_err < CMAX) m_err++;
                            if (!m_fv) begin
                                m_fv = 1'b1; m_fa = c.a; m_fb = c.b;
                                m_fos = c.os; m_fexp = c.exp;
                            end
                        end
                    end
                    if (drp) begin
                        if (m_drop < CMAX) m_drop++;
                        m_ovf = 1'b1;
                    end
                end
                check("ready", o_ready, 1);
                check("event", o_event, ev);
                check("chk_cnt", o_chk_cnt, m_chk);
                check("err_cnt", o_err_cnt, m_err);
                check("drop_cnt", o_drop_cnt, m_drop);
                check("overflow", o_overflow, m_ovf);
                check("first_vld", o_first_vld, CAP_EN ? m_fv : 1'b0);
                check("first_a", o_first_a, CAP_EN ? m_fa : '0);
                check("first_b", o_first_b, CAP_EN ? m_fb : '0);
                check("first_os", o_first_os, CAP_EN ? m_fos : '0);
                check("first_exp", o_first_exp, CAP_EN ? m_fexp : '0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [W-1:0] a, b, os;
        for (int l = 0; l < int'(NL); l++) free_at[l] = 0;
        reset_n  = 1'b1;
        i_clear  = 1'b0;
        i_valid  = 1'b0;
        i_dut_ia = '0;
        i_dut_ib = '0;
        i_dut_os = '0;
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);

        // Single correct sample, then single mismatching sample.
        drive(1'b1, 16'd3, 16'd5, 16'd8, 1'b0);
        idle(6);
        check("single_ok_chk", o_chk_cnt, 1);
        check("single_ok_err", o_err_cnt, 0);
        drive(1'b1, 16'd3, 16'd5, 16'd9, 1'b0);
        idle(6);
        check("single_bad_err", o_err_cnt, 1);

        // Back-to-back beyond lane capacity: the third and fourth samples drop.
        for (int i = 0; i < 4; i++) drive(1'b1, W'(i), W'(2 * i), W'(3 * i), 1'b0);
        idle(6);
        check("b2b_overflow", o_overflow, 1);

        // Two mismatches, capture holds the first, then clear.
        drive(1'b1, 16'd1, 16'd2, 16'h0010, 1'b1);
        idle(5);
        drive(1'b1, 16'd1, 16'd2, 16'h0020, 1'b0);
        idle(6);
        drive(1'b0, '0, '0, '0, 1'b1);
        idle(1);
        check("clr_err", o_err_cnt, 0);

        // Twenty mismatches, enough to saturate the 4-bit error counter.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, W'(i), 16'd7, 16'hffff, 1'b0);
            idle(3);
        end
        idle(4);
        check("err_saturated", o_err_cnt, CMAX);

        // Random traffic with occasional clears and a completion/clear collision mix.
        drive(1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            os = ($urandom_range(0, 3) == 0) ? W'($urandom) : ref_fn(a, b);
            drive(1'($urandom_range(0, 1)), a, b, os, $urandom_range(0, 40) == 0);
        end

        // Reset in the middle of traffic, then resume.
        for (int i = 0; i < 5; i++) drive(1'b1, W'(i), W'(i), W'(7), 1'b0);
        apply_reset("midreset");
        idle(1);
        for (int i = 0; i < 60; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            os = ($urandom_range(0, 2) == 0) ? W'($urandom) : ref_fn(a, b);
            drive(1'($urandom_range(0, 1)), a, b, os, 1'b0);
        end
        idle(int'(RL) + 6);

        check("drain_sb", sb_q.size(), 0);
        check("drain_drop", drop_q.size(), 0);
        check("drain_clr", clr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
